// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// mem_arbiter_pkg -- state, grant and request/response types shared by the memory arbiter.
// Rev 1.0
package mem_arbiter_pkg;

   // Upper bounds for the arbiter's AW/DW parameters; latched fields are stored at these widths.
   localparam int MAX_AW = 64;
   localparam int MAX_DW = 64;
   localparam int MAX_SW = MAX_DW / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   typedef struct packed {
      logic [MAX_AW-1:0] addr;
      logic              wen;
      logic [MAX_SW-1:0] strobe;
      logic [MAX_DW-1:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic              ok;
      logic [MAX_DW-1:0] data;
   } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter -- round-robin arbiter sharing one memory port between instruction and data requesters.
// Rev 1.0
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            reset,

   input  logic            ireq_valid,
   input  logic [AW-1:0]   ireq_addr,
   output logic            iresp_ok,
   output logic [31:0]     iresp_data,

   input  logic            dreq_valid,
   input  logic [AW-1:0]   dreq_addr,
   input  logic            dreq_wen,
   input  logic [DW/8-1:0] dreq_strobe,
   input  logic [DW-1:0]   dreq_wdata,
   output logic            dresp_ok,
   output logic [DW-1:0]   dresp_data,

   output logic            mem_valid,
   output logic [AW-1:0]   mem_addr,
   output logic            mem_wen,
   output logic [DW/8-1:0] mem_strobe,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_data_ok,
   input  logic [DW-1:0]   mem_rdata
);

   state_t    state;
   state_t    state_next;
   grant_t    last_grant;
   mem_req_t  req;
   mem_resp_t resp;
   logic      grant_i;
   logic      grant_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= GRANT_D;
         req        <= '0;
      end else begin
         state <= state_next;
         if (grant_i) begin
            last_grant <= GRANT_I;
            req.addr   <= MAX_AW'(ireq_addr);
            req.wen    <= 1'b0;
            req.strobe <= '0;
            req.wdata  <= '0;
         end else if (grant_d) begin
            last_grant <= GRANT_D;
            req.addr   <= MAX_AW'(dreq_addr);
            req.wen    <= dreq_wen;
            req.strobe <= MAX_SW'(dreq_strobe);
            req.wdata  <= MAX_DW'(dreq_wdata);
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state)
         IDLE: begin
            // Under contention the requester not served last wins.
            if (ireq_valid && (!dreq_valid || last_grant == GRANT_D)) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end else if (dreq_valid) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_data_ok) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // mem_data_ok is only meaningful while a transaction is outstanding.
   always_comb begin
      resp.ok   = mem_data_ok && (state != IDLE);
      resp.data = resp.ok ? MAX_DW'(mem_rdata) : '0;
   end

   assign iresp_ok   = resp.ok && (state == BUSY_I);
   assign dresp_ok   = resp.ok && (state == BUSY_D);
   assign iresp_data = resp.data[31:0] & {32{iresp_ok}};
   assign dresp_data = resp.data[DW-1:0] & {DW{dresp_ok}};

   assign mem_valid  = (state != IDLE);
   assign mem_addr   = req.addr[AW-1:0];
   assign mem_wen    = req.wen;
   assign mem_strobe = req.strobe[DW/8-1:0];
   assign mem_wdata  = req.wdata[DW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter -- directed scoreboard bench for mem_arbiter.
// Rev 1.0
module tb_mem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            ireq_valid;
   logic [AW-1:0]   ireq_addr;
   logic            iresp_ok;
   logic [31:0]     iresp_data;
   logic            dreq_valid;
   logic [AW-1:0]   dreq_addr;
   logic            dreq_wen;
   logic [DW/8-1:0] dreq_strobe;
   logic [DW-1:0]   dreq_wdata;
   logic            dresp_ok;
   logic [DW-1:0]   dresp_data;
   logic            mem_valid;
   logic [AW-1:0]   mem_addr;
   logic            mem_wen;
   logic [DW/8-1:0] mem_strobe;
   logic [DW-1:0]   mem_wdata;
   logic            mem_data_ok;
   logic [DW-1:0]   mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
      .iresp_ok(iresp_ok), .iresp_data(iresp_data),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_wen(dreq_wen),
      .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
      .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_strobe(mem_strobe), .mem_wdata(mem_wdata),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic [AW-1:0]   addr;
      logic            wen;
      logic [DW/8-1:0] strobe;
      logic [DW-1:0]   wdata;
   } mreq_t;

   typedef struct packed {
      logic          is_d;
      logic [DW-1:0] data;
   } rsp_t;

   localparam logic [DW-1:0] IDLE_RDATA = 64'hA5A5_5A5A_C3C3_3C3C;

   mreq_t req_q[$];
   rsp_t  rsp_q[$];
   int    errors  = 0;
   int    checks  = 0;
   logic  started = 1'b0;
   logic  prev_mv = 1'b0;
   logic  have_cur = 1'b0;
   mreq_t cur;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input logic [AW-1:0] a, input logic w, input logic [DW/8-1:0] s,
                           input logic [DW-1:0] d);
      mreq_t m;
      m.addr = a; m.wen = w; m.strobe = s; m.wdata = d;
      req_q.push_back(m);
   endtask

   task automatic push_rsp(input logic is_d, input logic [DW-1:0] d);
      rsp_t r;
      r.is_d = is_d; r.data = d;
      rsp_q.push_back(r);
   endtask

   // Wait (bounded) for an outstanding memory request, then complete it after lat more cycles.
   task automatic serve(input int lat, input logic [DW-1:0] rd);
      int n = 0;
      while (!mem_valid && n < 20) begin
         tick();
         n++;
      end
      if (!mem_valid) fail("serve_timeout");
      repeat (lat) tick();
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      tick();
      mem_data_ok = 1'b0;
      mem_rdata   = IDLE_RDATA;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      chk("rst_mem_valid",  64'(mem_valid),  64'd0);
      chk("rst_mem_addr",   64'(mem_addr),   64'd0);
      chk("rst_mem_wen",    64'(mem_wen),    64'd0);
      chk("rst_mem_strobe", 64'(mem_strobe), 64'd0);
      chk("rst_mem_wdata",  64'(mem_wdata),  64'd0);
      chk("rst_iresp_ok",   64'(iresp_ok),   64'd0);
      chk("rst_dresp_ok",   64'(dresp_ok),   64'd0);
      reset = 1'b0;
   endtask

   // Monitor: pops the request queue on each new mem_valid, the response queue on each resp_ok.
   always @(negedge clk) begin
      if (started) begin
         if (mem_valid && !prev_mv) begin
            if (req_q.size() == 0) begin
               fail("unexpected_mem_req");
            end else begin
               cur = req_q.pop_front();
               have_cur = 1'b1;
               chk("mem_addr",   64'(mem_addr),   64'(cur.addr));
               chk("mem_wen",    64'(mem_wen),    64'(cur.wen));
               chk("mem_strobe", 64'(mem_strobe), 64'(cur.strobe));
               chk("mem_wdata",  64'(mem_wdata),  64'(cur.wdata));
            end
         end else if (mem_valid && have_cur) begin
            chk("hold_addr",  64'(mem_addr),  64'(cur.addr));
            chk("hold_ctrl",  64'({mem_wen, mem_strobe}), 64'({cur.wen, cur.strobe}));
            chk("hold_wdata", 64'(mem_wdata), 64'(cur.wdata));
         end
         if (!mem_valid) have_cur = 1'b0;
         prev_mv = mem_valid;

         if (iresp_ok && dresp_ok) begin
            fail("both_resp_ok");
         end else if (iresp_ok || dresp_ok) begin
            if (rsp_q.size() == 0) begin
               fail("unexpected_resp");
            end else begin
               rsp_t r;
               r = rsp_q.pop_front();
               chk("resp_port", 64'(dresp_ok), 64'(r.is_d));
               chk("resp_data", dresp_ok ? 64'(dresp_data) : 64'(iresp_data), 64'(r.data));
            end
         end
         if (!iresp_ok) chk("iresp_data_zero", 64'(iresp_data), 64'd0);
         if (!dresp_ok) chk("dresp_data_zero", 64'(dresp_data), 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ireq_valid = 1'b0; ireq_addr = '0;
      dreq_valid = 1'b0; dreq_addr = '0; dreq_wen = 1'b0; dreq_strobe = '0; dreq_wdata = '0;
      mem_data_ok = 1'b0; mem_rdata = IDLE_RDATA;
      tick();
      do_reset();
      started = 1'b1;

      // Instruction fetch with fixed latency.
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
      push_req(64'h8000_0000, 1'b0, '0, '0);
      push_rsp(1'b0, 64'h0000_0000_0010_0093);
      tick();                                        // T+1
      chk("fetch_valid_t1", 64'(mem_valid), 64'd1);
      tick();                                        // T+2
      tick();                                        // T+3
      mem_data_ok = 1'b1; mem_rdata = 64'h0000_0000_0010_0093;
      #1;
      chk("fetch_iresp_ok", 64'(iresp_ok), 64'd1);
      chk("fetch_iresp_data", 64'(iresp_data), 64'h0010_0093);
      tick();                                        // T+4
      mem_data_ok = 1'b0; mem_rdata = IDLE_RDATA; ireq_valid = 1'b0;
      chk("fetch_valid_t4", 64'(mem_valid), 64'd0);
      tick();

      // Data store.
      dreq_valid = 1'b1; dreq_wen = 1'b1; dreq_strobe = 8'hFF;
      dreq_wdata = 64'hDEAD_BEEF_0000_0001; dreq_addr = 64'h8000_1000;
      push_req(64'h8000_1000, 1'b1, 8'hFF, 64'hDEAD_BEEF_0000_0001);
      push_rsp(1'b1, 64'h0123_4567_89AB_CDEF);
      serve(2, 64'h0123_4567_89AB_CDEF);
      dreq_valid = 1'b0;
      chk("store_single_pulse", 64'(dresp_ok), 64'd0);
      chk("store_idle", 64'(mem_valid), 64'd0);
      tick();

      // Contention after reset: I, D, I, D.
      do_reset();
      ireq_valid = 1'b1; ireq_addr = 64'h0000_0000_0000_1000;
      dreq_valid = 1'b1; dreq_wen = 1'b0; dreq_strobe = '0; dreq_wdata = '0;
      dreq_addr  = 64'h0000_0000_0000_2000;
      push_req(64'h1000, 1'b0, '0, '0);
      push_req(64'h2000, 1'b0, '0, '0);
      push_req(64'h1004, 1'b0, '0, '0);
      push_req(64'h2008, 1'b0, '0, '0);
      push_rsp(1'b0, 64'h0000_0000_1111_1111);
      push_rsp(1'b1, 64'h2222_2222_2222_2222);
      push_rsp(1'b0, 64'h0000_0000_3333_3333);
      push_rsp(1'b1, 64'h4444_4444_4444_4444);
      serve(1, 64'h0000_0000_1111_1111);
      ireq_addr = 64'h1004;
      serve(1, 64'h2222_2222_2222_2222);
      dreq_addr = 64'h2008;
      serve(1, 64'h0000_0000_3333_3333);
      ireq_valid = 1'b0;
      serve(1, 64'h4444_4444_4444_4444);
      dreq_valid = 1'b0;
      tick();

      // Flush: instruction requester drops valid mid-transaction.
      ireq_valid = 1'b1; ireq_addr = 64'h8000_0040;
      push_req(64'h8000_0040, 1'b0, '0, '0);
      push_rsp(1'b0, 64'h0000_0000_0040_0513);
      tick();                                        // T+1
      chk("flush_valid_t1", 64'(mem_valid), 64'd1);
      tick();                                        // T+2
      ireq_valid = 1'b0; ireq_addr = 64'hFFFF_0000_FFFF_0000;
      tick();                                        // T+3
      chk("flush_valid_t3", 64'(mem_valid), 64'd1);
      tick();                                        // T+4
      mem_data_ok = 1'b1; mem_rdata = 64'hFFFF_FFFF_0040_0513;
      #1;
      chk("flush_valid_t4", 64'(mem_valid), 64'd1);
      chk("flush_iresp_ok", 64'(iresp_ok), 64'd1);
      tick();                                        // T+5
      mem_data_ok = 1'b0; mem_rdata = IDLE_RDATA;
      chk("flush_idle_t5", 64'(mem_valid), 64'd0);
      tick();

      // Reset in the middle of a data transaction.
      dreq_valid = 1'b1; dreq_wen = 1'b0; dreq_addr = 64'h8000_2000;
      push_req(64'h8000_2000, 1'b0, '0, '0);
      tick();                                        // T+1
      tick();                                        // T+2
      reset = 1'b1;
      tick();                                        // T+3
      reset = 1'b0; dreq_valid = 1'b0;
      mem_data_ok = 1'b1; mem_rdata = 64'h5555_6666_7777_8888;
      #1;
      chk("abort_valid_t3", 64'(mem_valid), 64'd0);
      chk("abort_dresp_ok", 64'(dresp_ok), 64'd0);
      tick();                                        // T+4
      mem_data_ok = 1'b0; mem_rdata = IDLE_RDATA;
      chk("abort_idle_t4", 64'(mem_valid), 64'd0);
      tick();

      // Stability: data fields churn every cycle while the store is outstanding.
      dreq_valid = 1'b1; dreq_wen = 1'b1; dreq_strobe = 8'h0F;
      dreq_addr = 64'h8000_3000; dreq_wdata = 64'h0BAD_F00D_1234_5678;
      push_req(64'h8000_3000, 1'b1, 8'h0F, 64'h0BAD_F00D_1234_5678);
      push_rsp(1'b1, 64'h9999_AAAA_BBBB_CCCC);
      tick();
      for (int i = 0; i < 6; i++) begin
         dreq_addr   = {$urandom, $urandom};
         dreq_wdata  = {$urandom, $urandom};
         dreq_wen    = 1'($urandom);
         dreq_strobe = 8'($urandom);
         ireq_addr   = {$urandom, $urandom};
         tick();
      end
      serve(0, 64'h9999_AAAA_BBBB_CCCC);
      dreq_valid = 1'b0;
      tick();
      tick();

      chk("req_q_drained", 64'(req_q.size()), 64'd0);
      chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL take parameter AW, default 64, meaning address width.
REQ-002 SHALL take parameter DW, default 64, meaning data width.
REQ-003 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-high.
REQ-004 SHALL have instruction-requester ports, all in unless noted: ireq_valid 1; ireq_addr AW; iresp_ok out 1; iresp_data out 32.
REQ-005 SHALL have data-requester ports, all in unless noted: dreq_valid 1; dreq_addr AW; dreq_wen 1; dreq_strobe DW/8; dreq_wdata DW; dresp_ok out 1; dresp_data out DW.
REQ-006 SHALL have memory-side ports: mem_valid out 1; mem_addr out AW; mem_wen out 1; mem_strobe out DW/8; mem_wdata out DW; mem_data_ok in 1; mem_rdata in DW.

Function
REQ-007 SHALL implement FSM states IDLE, BUSY_I and BUSY_D.
REQ-008 In IDLE with only ireq_valid high, SHALL latch the instruction request and go to BUSY_I; the latched request is addr, wen=0, strobe=0.
REQ-009 In IDLE with only dreq_valid high, SHALL latch addr, wen, strobe and wdata, and go to BUSY_D.
REQ-010 In IDLE with both requests valid, SHALL grant the requester not served last (round-robin via a last_grant register).
REQ-011 SHALL update last_grant on every grant.
REQ-012 SHALL drive mem_valid and the mem_* fields from the latched registers only, never combinationally from the requester inputs.
REQ-013 Grant in cycle T SHALL give mem_valid=1 from cycle T+1.
REQ-014 In BUSY_x, SHALL hold mem_valid=1 and the mem_* fields stable until mem_data_ok=1.
REQ-015 In the cycle where mem_data_ok=1 in BUSY_I, SHALL drive iresp_ok=1 and iresp_data=mem_rdata[31:0] combinationally, and return to IDLE.
REQ-016 In the cycle where mem_data_ok=1 in BUSY_D, SHALL drive dresp_ok=1 and dresp_data=mem_rdata combinationally, and return to IDLE.
REQ-017 SHALL produce no same-cycle regrant; there is at least one IDLE cycle between transactions.
REQ-018 Requesters hold valid and fields until their resp_ok and drop valid the next cycle; the arbiter SHALL rely on this.
REQ-019 A requester deasserting valid mid-transaction (flush) SHALL NOT abort the transaction; the transaction completes and resp_ok still pulses.
REQ-020 SHALL ignore mem_data_ok while in IDLE.
REQ-021 The resp_ok output of the non-granted requester SHALL stay 0.
REQ-022 iresp_data and dresp_data SHALL be 0 whenever the matching resp_ok is 0.
REQ-023 Changes on the requester input fields during BUSY SHALL have no effect on the mem_* outputs.

Reset
REQ-024 On reset, SHALL go to state=IDLE and last_grant=D, so the first contended grant goes to I.
REQ-025 On reset, all latched fields SHALL be 0.
REQ-026 In the cycle after reset is sampled high, outputs SHALL be: mem_valid=0, mem_* fields 0, iresp_ok=0, dresp_ok=0.
REQ-027 Reset mid-transaction SHALL abandon the transaction with no resp_ok pulse; a late mem_data_ok is then ignored per REQ-020.

Structure
REQ-028 The state enum (IDLE/BUSY_I/BUSY_D) and the grant id type (GRANT_I/GRANT_D) SHALL live in the shared common package.
REQ-029 The request/response struct typedefs SHALL live in the shared common package.
REQ-030 SHALL be a single module with no sub-module; the round-robin pick is inline logic.

Verification
REQ-031 Instruction fetch: ireq_valid=1, addr=0x8000_0000 at T -> mem_valid=1, mem_addr=0x8000_0000, mem_wen=0 at T+1; mem_data_ok=1 with rdata=0x0000_0000_0010_0093 at T+3 -> iresp_ok=1, iresp_data=0x00100093 at T+3; mem_valid=0 at T+4.
REQ-032 Data store: dreq_valid=1, wen=1, strobe=0xFF, wdata=0xDEAD_BEEF_0000_0001, addr=0x8000_1000 -> mem fields match exactly while held; dresp_ok pulses for exactly one cycle on mem_data_ok.
REQ-033 Contention after reset: both valid at T -> I granted first; after the I completion, with both still valid -> D granted; the next contention -> I.
REQ-034 Flush: ireq_valid dropped at T+2 of a BUSY_I with mem_data_ok at T+4 -> mem_valid held T+1..T+4; iresp_ok=1 at T+4; state is IDLE at T+5.
REQ-035 Reset at T+2 of BUSY_D with mem_data_ok=1 at T+3 -> mem_valid=0 at T+3, no dresp_ok pulse, state IDLE.
REQ-036 Stability: randomise the dreq_* fields every cycle during BUSY_D -> the mem_* outputs stay equal to the values latched at grant.
